vote_persist_filter: RTL and testbench
======================================

# vote_persist_filter

Persistence filter placed directly downstream of the 4-input 3-of-4 voter. It samples the single-bit vote result and changes its filtered output only after the vote has held a new value for HOLD consecutive qualified samples. It emits one-cycle edge pulses, keeps a latched alarm with an acknowledge handshake, and maintains a saturating count of filtered rising events for status readout.

## Interface

Parameters:
- HOLD, default 4: number of consecutive qualified samples required to change `filt`. Legal range is 2 to 255.
- CNT_W, default 8: width of the `trips` counter.

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `vote`  input  1  3-of-4 voter output; high means at least three of the four channels are high.
- `sample_en`  input  1  qualifies sampling of `vote`; when low, the block holds all state.
- `ack`  input  1  clears `alarm`.
- `filt`  output  1  filtered vote value, registered.
- `rise`  output  1  one-cycle pulse when `filt` goes 0 to 1.
- `fall`  output  1  one-cycle pulse when `filt` goes 1 to 0.
- `alarm`  output  1  set by `rise`, held until `ack`.
- `trips`  output  CNT_W  saturating count of `rise` events.

## Operation

FSM states:
- LO: `filt` = 0, stable.
- QUAL_HI: counting consecutive samples with `vote` = 1.
- HI: `filt` = 1, stable.
- QUAL_LO: counting consecutive samples with `vote` = 0.

Qualification counter:
- `run` is ceil(log2(HOLD+1)) bits wide.

Transitions are evaluated only on edges where `sample_en` = 1:
- LO, `vote` = 1: go to QUAL_HI, `run` = 1.
- LO, `vote` = 0: stay in LO.
- QUAL_HI, `vote` = 1, `run` = HOLD-1: go to HI, `filt` = 1, pulse `rise`, `run` = 0.
- QUAL_HI, `vote` = 1, other `run` values: `run` increments.
- QUAL_HI, `vote` = 0: return to LO, `run` = 0, no output change.
- HI and QUAL_LO mirror LO and QUAL_HI with `vote` inverted. Completion sets `filt` = 0 and pulses `fall`.

When `sample_en` = 0:
- State, `run`, `filt`, `alarm` and `trips` hold.
- `rise` and `fall` are 0.
- A disabled edge does not break a qualification run.

`alarm`:
- Set on the edge that asserts `rise`.
- Cleared on an edge with `ack` = 1 and no concurrent `rise`.
- If `ack` and `rise` occur on the same edge, set wins and `alarm` stays 1.

`trips`:
- Increments by 1 on each `rise`.
- Saturates at 2^CNT_W − 1.
- Never wraps.

## Timing

Reset:
- `rst` sampled high forces state = LO, `run` = 0.
- Outputs after reset: `filt` = 0, `rise` = 0, `fall` = 0, `alarm` = 0, `trips` = 0.
- Reset overrides `sample_en`, `vote` and `ack`.
- Reset during QUAL_HI or QUAL_LO aborts the run. A full HOLD samples are needed afterwards.

Latency:
- With `sample_en` held high, `filt` changes on the edge that samples the HOLD-th consecutive qualifying `vote`.
- Example: the first qualifying sample is on edge k, so `filt` changes after edge k+HOLD−1.
- `rise` and `fall` are high for exactly the cycle following that edge, coincident with the new `filt` value.
- `alarm` and `trips` update on the same edge as `rise`.
- `ack` takes effect one edge after it is sampled. `alarm` is low the next cycle.

Boundary conditions:
- A single-sample glitch of the opposite value during QUAL_* restarts from the stable state.
- A qualifying sample in LO or HI that matches the current `filt` is ignored.
- `rise` and `fall` are never both high.
- Minimum spacing between a `rise` and the next `fall` is HOLD qualified samples.
- At saturation, a further `rise` still pulses and still sets `alarm`. `trips` holds.

## Test plan

1. Reset, then `vote` = 1 and `sample_en` = 1 held, HOLD = 4 → `filt` goes high after the 4th edge. `rise` is high for 1 cycle, `trips` = 1, `alarm` = 1.
2. From LO, `vote` = 1 for 3 sampled edges then 0 → `filt`, `rise` and `trips` stay 0, and the state returns to LO. Repeating with 4 samples gives `filt` = 1.
3. `vote` = 1 with `sample_en` pattern 1,0,1,0,1,0,1 → `filt` rises after the 7th edge (4th enabled sample). No pulse occurs on disabled edges.
4. From HI, `vote` = 0 for 4 samples → `fall` pulses once, `filt` = 0, `trips` unchanged.
5. Alarm handshake:
   - With `alarm` = 1, pulse `ack` alone → `alarm` = 0 next cycle.
   - Then drive `ack` = 1 on the same edge as a new `rise` → `alarm` = 1 and `trips` increments.
6. Saturation and reset:
   - With CNT_W = 2, run 5 full rise/fall cycles → `trips` reads 1, 2, 3, 3, 3.
   - Then assert `rst` after 2 samples in QUAL_HI → all outputs 0, and 4 fresh samples are required to raise `filt`.

Source files
------------

// File: rtl/vote_persist_filter.sv
// vote_persist_filter
// Persistence filter for the 3-of-4 voter output. The filtered value only
// changes once the vote has held a new level for HOLD consecutive qualified
// samples. The block also produces one-cycle rise/fall pulses, a latched
// alarm with acknowledge, and a saturating count of filtered rising events.
module vote_persist_filter #(
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vote,
  input  logic             sample_en,
  input  logic             ack,
  output logic             filt,
  output logic             rise,
  output logic             fall,
  output logic             alarm,
  output logic [CNT_W-1:0] trips
);

  localparam int RUN_W = $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HOLD - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] TRIPS_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    LO      = 2'd0,
    QUAL_HI = 2'd1,
    HI      = 2'd2,
    QUAL_LO = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next;

  logic             filt_next;
  logic             rise_next;
  logic             fall_next;
  logic             alarm_next;
  logic [CNT_W-1:0] trips_next;

  // State and qualification-run register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LO;
      run   <= '0;
    end else begin
      state <= state_next;
      run   <= run_next;
    end
  end

  // Next-state logic: only qualified samples move the FSM, so a disabled edge leaves a run intact.
  always_comb begin
    state_next = state;
    run_next   = run;
    if (sample_en) begin
      unique case (state)
        LO: begin
          if (vote) begin
            state_next = QUAL_HI;
            run_next   = RUN_ONE;
          end
        end
        QUAL_HI: begin
          if (!vote) begin
            state_next = LO;
            run_next   = '0;
          end else if (run == RUN_LAST) begin
            state_next = HI;
            run_next   = '0;
          end else begin
            run_next = run + RUN_ONE;
          end
        end
        HI: begin
          if (!vote) begin
            state_next = QUAL_LO;
            run_next   = RUN_ONE;
          end
        end
        QUAL_LO: begin
          if (vote) begin
            state_next = HI;
            run_next   = '0;
          end else if (run == RUN_LAST) begin
            state_next = LO;
            run_next   = '0;
          end else begin
            run_next = run + RUN_ONE;
          end
        end
        default: begin
          state_next = LO;
          run_next   = '0;
        end
      endcase
    end
  end

  // Output logic: completion of a run pulses rise/fall and updates filt, alarm and trips together.
  always_comb begin
    rise_next  = sample_en && (state == QUAL_HI) && vote && (run == RUN_LAST);
    fall_next  = sample_en && (state == QUAL_LO) && !vote && (run == RUN_LAST);
    filt_next  = filt;
    alarm_next = alarm;
    trips_next = trips;
    if (rise_next) begin
      filt_next  = 1'b1;
      alarm_next = 1'b1;
      if (trips != TRIPS_MAX) begin
        trips_next = trips + CNT_W'(1);
      end
    end else if (fall_next) begin
      filt_next = 1'b0;
    end
    if (sample_en && ack && !rise_next) begin
      alarm_next = 1'b0;
    end
  end

  // Output registers; everything user-visible is registered and cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      alarm <= 1'b0;
      trips <= '0;
    end else begin
      filt  <= filt_next;
      rise  <= rise_next;
      fall  <= fall_next;
      alarm <= alarm_next;
      trips <= trips_next;
    end
  end

endmodule

// File: tb/tb_vote_persist_filter.sv
// tb_vote_persist_filter
// Drives two filter instances (8-bit and 2-bit trip counters) from the same
// inputs. A behavioural model predicts each edge's outputs, which are queued
// when the stimulus is applied and compared when the DUT has clocked.
module tb_vote_persist_filter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic       vote;
  logic       sample_en;
  logic       ack;
  logic       filt_a, rise_a, fall_a, alarm_a;
  logic [7:0] trips_a;
  logic       filt_b, rise_b, fall_b, alarm_b;
  logic [1:0] trips_b;

  typedef struct packed {
    logic       filt;
    logic       rise;
    logic       fall;
    logic       alarm;
    logic [7:0] trips8;
    logic [1:0] trips2;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  // Reference model state
  logic       m_filt;
  logic       m_rise;
  logic       m_fall;
  logic       m_alarm;
  logic [7:0] m_trips8;
  logic [1:0] m_trips2;
  int         m_cnt;

  vote_persist_filter #(.HOLD(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vote(vote), .sample_en(sample_en), .ack(ack),
    .filt(filt_a), .rise(rise_a), .fall(fall_a), .alarm(alarm_a), .trips(trips_a)
  );

  vote_persist_filter #(.HOLD(HOLD), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .vote(vote), .sample_en(sample_en), .ack(ack),
    .filt(filt_b), .rise(rise_b), .fall(fall_b), .alarm(alarm_b), .trips(trips_b)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: count consecutive qualified samples that disagree with the filtered value
  task automatic model_edge(input logic r, input logic en, input logic v, input logic a);
    if (r) begin
      m_filt = 0; m_rise = 0; m_fall = 0; m_alarm = 0;
      m_trips8 = 0; m_trips2 = 0; m_cnt = 0;
    end else if (en) begin
      m_rise = 0;
      m_fall = 0;
      if (v != m_filt) begin
        m_cnt++;
        if (m_cnt == HOLD) begin
          m_filt = v;
          m_cnt  = 0;
          if (v) m_rise = 1; else m_fall = 1;
        end
      end else begin
        m_cnt = 0;
      end
      if (m_rise) begin
        m_alarm = 1;
        if (m_trips8 != 8'hFF) m_trips8 = m_trips8 + 8'd1;
        if (m_trips2 != 2'h3)  m_trips2 = m_trips2 + 2'd1;
      end else if (a) begin
        m_alarm = 0;
      end
    end else begin
      m_rise = 0;
      m_fall = 0;
    end
  endtask

  task automatic check_field(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL step %0d %s: observed=%0h expected=%0h", step_no, tag, obs, expv);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL step %0d scoreboard: observed=empty expected=entry", step_no);
      return;
    end
    e = exp_q.pop_front();
    check_field("filt",       {7'd0, filt_a},  {7'd0, e.filt});
    check_field("rise",       {7'd0, rise_a},  {7'd0, e.rise});
    check_field("fall",       {7'd0, fall_a},  {7'd0, e.fall});
    check_field("alarm",      {7'd0, alarm_a}, {7'd0, e.alarm});
    check_field("trips",      trips_a,         e.trips8);
    check_field("sat_filt",   {7'd0, filt_b},  {7'd0, e.filt});
    check_field("sat_alarm",  {7'd0, alarm_b}, {7'd0, e.alarm});
    check_field("sat_trips",  {6'd0, trips_b}, {6'd0, e.trips2});
  endtask

  // One clock edge: drive inputs, queue the prediction, then compare after the edge
  task automatic apply_stimulus(input logic r, input logic en, input logic v, input logic a);
    @(negedge clk);
    rst = r; sample_en = en; vote = v; ack = a;
    model_edge(r, en, v, a);
    exp_q.push_back('{m_filt, m_rise, m_fall, m_alarm, m_trips8, m_trips2});
    @(posedge clk);
    #1;
    step_no++;
    check_output();
  endtask

  task automatic run_vote(input logic v, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 1, v, 0);
  endtask

  initial begin
    rst = 1; sample_en = 0; vote = 0; ack = 0;
    m_filt = 0; m_rise = 0; m_fall = 0; m_alarm = 0;
    m_trips8 = 0; m_trips2 = 0; m_cnt = 0;

    $display("[TB] reset");
    apply_stimulus(1, 1, 1, 1);
    apply_stimulus(1, 0, 0, 0);

    $display("[TB] basic rise after HOLD samples");
    run_vote(1, 4);
    run_vote(1, 2);

    $display("[TB] fall after HOLD low samples");
    run_vote(0, 4);
    run_vote(0, 1);

    $display("[TB] aborted run then full run");
    run_vote(1, 3);
    run_vote(0, 1);
    run_vote(1, 4);

    $display("[TB] glitch during low qualification");
    run_vote(0, 2);
    run_vote(1, 1);
    run_vote(0, 4);

    $display("[TB] gated sampling");
    for (int i = 0; i < 7; i++) apply_stimulus(0, (i % 2 == 0), 1, 0);
    apply_stimulus(0, 0, 0, 0);
    run_vote(1, 1);

    $display("[TB] alarm handshake");
    apply_stimulus(0, 1, 1, 1);
    apply_stimulus(0, 1, 1, 0);
    run_vote(0, 4);
    run_vote(1, 3);
    apply_stimulus(0, 1, 1, 1);
    apply_stimulus(0, 1, 1, 0);

    $display("[TB] saturation");
    apply_stimulus(1, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      run_vote(1, 4);
      run_vote(0, 4);
    end

    $display("[TB] reset aborts qualification");
    run_vote(1, 2);
    apply_stimulus(1, 1, 1, 0);
    run_vote(1, 3);
    run_vote(1, 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 5) < 4) ^ ((i / 40) % 2 == 1),
                     ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
